apb_req_arbiter: RTL and testbench

//  APB requester that shares one 16x8 APB register-file responder between NREQ

---
 rtl/apb_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// APB requester that shares one responder among NREQ clients by round-robin.
// Runs the SETUP/ACCESS handshake, waits on pready with a timeout, and returns done/err/rdata.
module apb_req_arbiter #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned AW      = 4,
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              prstn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   req_done,
   output logic              req_err,
   output logic [DW-1:0]     req_rdata,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [AW-1:0]     paddr,
   output logic [DW-1:0]     pwdata,
   input  logic              pready,
   input  logic [DW-1:0]     prdata
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   winner_q, winner_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
   logic            grant_vld;
   logic [IW-1:0]   grant_idx;

   logic            psel_d, penable_d, pwrite_d, req_err_d;
   logic [AW-1:0]   paddr_d;
   logic [DW-1:0]   pwdata_d, req_rdata_d;
   logic [NREQ-1:0] req_done_d;

   // Client index 'ofs' positions after 'base', wrapping at NREQ.
   function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int unsigned ofs);
      int unsigned sum;
      sum = 32'(base) + ofs;
      if (sum >= NREQ) sum = sum - NREQ;
      return IW'(sum);
   endfunction

   // First requesting client at or after rr_ptr.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!grant_vld && req_valid[rr_index(rr_ptr_q, i)]) begin
            grant_vld = 1'b1;
            grant_idx = rr_index(rr_ptr_q, i);
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge pclk) begin
      if (!prstn) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         winner_q   <= '0;
         wait_cnt_q <= '0;
         psel       <= 1'b0;
         penable    <= 1'b0;
         pwrite     <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
         req_done   <= '0;
         req_err    <= 1'b0;
         req_rdata  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         winner_q   <= winner_d;
         wait_cnt_q <= wait_cnt_d;
         psel       <= psel_d;
         penable    <= penable_d;
         pwrite     <= pwrite_d;
         paddr      <= paddr_d;
         pwdata     <= pwdata_d;
         req_done   <= req_done_d;
         req_err    <= req_err_d;
         req_rdata  <= req_rdata_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_vld) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (pready || (wait_cnt_q == WAIT_LAST)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and bookkeeping.
   always_comb begin
      psel_d      = psel;
      penable_d   = penable;
      pwrite_d    = pwrite;
      paddr_d     = paddr;
      pwdata_d    = pwdata;
      req_done_d  = '0;
      req_err_d   = 1'b0;
      req_rdata_d = req_rdata;
      winner_d    = winner_q;
      rr_ptr_d    = rr_ptr_q;
      wait_cnt_d  = wait_cnt_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               psel_d    = 1'b1;
               penable_d = 1'b0;
               winner_d  = grant_idx;
               pwrite_d  = req_write[grant_idx];
               paddr_d   = req_addr[32'(grant_idx)*AW +: AW];
               pwdata_d  = req_wdata[32'(grant_idx)*DW +: DW];
            end
         end
         SETUP: penable_d = 1'b1;
         ACCESS: begin
            if (pready) begin
               psel_d               = 1'b0;
               penable_d            = 1'b0;
               req_done_d[winner_q] = 1'b1;
               if (!pwrite) req_rdata_d = prdata;
            end else if (wait_cnt_q == WAIT_LAST) begin
               psel_d               = 1'b0;
               penable_d            = 1'b0;
               req_done_d[winner_q] = 1'b1;
               req_err_d            = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         DONE: begin
            wait_cnt_d = '0;
            rr_ptr_d   = (winner_q == LAST_IDX) ? '0 : winner_q + IW'(1);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a register-file responder with programmable stall,
// stimulus pushes expected completions, a monitor pops and checks them on each req_done.
module tb_apb_req_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 4;
   localparam int DW   = 8;

   logic              pclk = 1'b0;
   logic              prstn;
   logic [NREQ-1:0]   req_valid, req_write;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]   req_done;
   logic              req_err;
   logic [DW-1:0]     req_rdata;
   logic              psel, penable, pwrite;
   logic [AW-1:0]     paddr;
   logic [DW-1:0]     pwdata;
   logic              pready;
   logic [DW-1:0]     prdata;

   typedef struct {
      int            client;
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t          exp_q[$];
   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] mem [16];
   bit            mem_init = 1'b0;
   int            acc_cnt = 0;
   int            stall_n = 0;
   int            r_psel, r_pen, r_done, r_acc;
   bit            r_stable;

   apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
      .pclk(pclk), .prstn(prstn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pready(pready), .prdata(prdata)
   );

   always #5 pclk = ~pclk;

   // Responder: ready after stall_n wait cycles in ACCESS; prdata only on a completing read.
   assign pready = psel && penable && (acc_cnt >= stall_n);
   assign prdata = (psel && penable && !pwrite && pready) ? mem[paddr] : '0;

   always @(posedge pclk) begin
      if (!mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h40 + i);
         mem_init <= 1'b1;
      end else if (psel && penable && pready && pwrite) begin
         mem[paddr] <= pwdata;
      end
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_done(input int c, input logic e, input logic [DW-1:0] d);
      exp_t x;
      x.client = c;
      x.err    = e;
      x.rdata  = d;
      exp_q.push_back(x);
   endtask

   // Monitor: scoreboard pop on every req_done, plus minimum psel-low gap.
   initial begin : monitor
      exp_t e;
      int   low_run = 100;
      bit   psel_prev = 1'b0;
      forever begin
         @(negedge pclk);
         if (req_done !== '0) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL done_unexpected: req_done=%b with empty scoreboard", req_done);
            end else begin
               e = exp_q.pop_front();
               check("done_client", 32'(req_done), 32'(1 << e.client));
               check("done_err", 32'(req_err), 32'(e.err));
               check("done_rdata", 32'(req_rdata), 32'(e.rdata));
            end
         end
         if (psel === 1'b1 && !psel_prev) check("psel_gap_ge2", 32'(low_run >= 2), 32'(1));
         if (psel === 1'b1) low_run = 0;
         else low_run++;
         psel_prev = (psel === 1'b1);
      end
   end

   // One request from client c; records phase timing, ACCESS count and bus stability.
   task automatic run_txn(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      int cyc = 0;
      int tp = -1, te = -1, td = -1, acc = 0;
      bit stable = 1'b1;
      req_write[c]          = wr;
      req_addr[c*AW +: AW]  = a;
      req_wdata[c*DW +: DW] = wd;
      req_valid[c]          = 1'b1;
      while (td < 0 && cyc < 100) begin
         @(negedge pclk);
         cyc++;
         if (psel && tp < 0) tp = cyc;
         if (psel && !(paddr == a && pwrite == wr && pwdata == wd)) stable = 1'b0;
         if (psel && penable) begin
            acc++;
            if (te < 0) te = cyc;
         end
         if (req_done[c]) td = cyc;
      end
      req_valid[c] = 1'b0;
      if (td < 0) begin
         tests++;
         fails++;
         $display("FAIL txn_timeout: client %0d got no req_done within 100 cycles", c);
      end
      r_psel = tp; r_pen = te; r_done = td; r_acc = acc; r_stable = stable;
   endtask

   task automatic xfer(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic e, input logic [DW-1:0] d);
      expect_done(c, e, d);
      run_txn(c, wr, a, wd);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time budget exceeded");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      prstn = 1'b0; req_valid = '1; req_write = '0; req_addr = '0; req_wdata = '0;
      // Reset with both clients requesting
      repeat (2) @(negedge pclk);
      check("reset_outputs", 32'({req_done, req_err, req_rdata, psel, penable, pwrite, paddr, pwdata}), 32'(0));
      prstn = 1'b1;
      expect_done(0, 1'b0, 8'h40);
      expect_done(1, 1'b0, 8'h41);
      fork
         run_txn(0, 1'b0, 4'd0, 8'h00);
         run_txn(1, 1'b0, 4'd1, 8'h00);
      join

      // Single write: phase timing and stable bus
      repeat (2) @(negedge pclk);
      xfer(0, 1'b1, 4'd3, 8'hA5, 1'b0, 8'h41);
      check("t_psel", 32'(r_psel), 32'(1));
      check("t_penable", 32'(r_pen), 32'(2));
      check("t_done", 32'(r_done), 32'(3));
      check("wr_bus_stable", 32'(r_stable), 32'(1));
      xfer(0, 1'b0, 4'd3, 8'h00, 1'b0, 8'hA5);
      xfer(1, 1'b1, 4'd5, 8'h3C, 1'b0, 8'hA5);

      // Both clients back-to-back: strict alternation 0,1,0,1
      expect_done(0, 1'b0, 8'hA5);
      expect_done(1, 1'b0, 8'hA5);
      expect_done(0, 1'b0, 8'h3C);
      expect_done(1, 1'b0, 8'h11);
      fork
         begin run_txn(0, 1'b1, 4'd7, 8'h11); run_txn(0, 1'b0, 4'd5, 8'h00); end
         begin run_txn(1, 1'b1, 4'd8, 8'h22); run_txn(1, 1'b0, 4'd7, 8'h00); end
      join

      // pready never comes: abort after 16 ACCESS cycles, rdata unchanged
      repeat (2) @(negedge pclk);
      stall_n = 1000;
      xfer(0, 1'b0, 4'd3, 8'h00, 1'b1, 8'h11);
      check("timeout_access_cycles", 32'(r_acc), 32'(16));

      // Three wait cycles then ready
      stall_n = 3;
      xfer(1, 1'b1, 4'd9, 8'h5A, 1'b0, 8'h11);
      check("stall_access_cycles", 32'(r_acc), 32'(4));
      check("stall_bus_stable", 32'(r_stable), 32'(1));
      stall_n = 0;
      xfer(0, 1'b0, 4'd9, 8'h00, 1'b0, 8'h5A);

      // Reset during ACCESS aborts without a completion
      stall_n = 1000;
      req_write[1] = 1'b0; req_addr[AW +: AW] = 4'd3; req_valid[1] = 1'b1;
      n = 0;
      while (!(psel === 1'b1 && penable === 1'b1) && n < 50) begin
         @(negedge pclk);
         n++;
      end
      if (n >= 50) begin
         tests++;
         fails++;
         $display("FAIL access_wait: ACCESS phase not reached within 50 cycles");
      end
      @(negedge pclk);
      prstn = 1'b0;
      req_valid = '1; req_write = '0;
      req_addr[0 +: AW] = 4'd9; req_addr[AW +: AW] = 4'd3;
      @(negedge pclk);
      check("reset_abort", 32'({psel, penable, req_done}), 32'(0));
      stall_n = 0;
      @(negedge pclk);
      prstn = 1'b1;
      expect_done(0, 1'b0, 8'h5A);
      expect_done(1, 1'b0, 8'hA5);
      fork
         run_txn(0, 1'b0, 4'd9, 8'h00);
         run_txn(1, 1'b0, 4'd3, 8'h00);
      join

      repeat (3) @(negedge pclk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
